// File: rtl/phytx_pkg.sv
// phytx_pkg: shared constants and encodings for the PHY transmit word scheduler
package phytx_pkg;
  localparam logic [31:0] COM_WORD_DEF = 32'hBCBCBCBC;
  typedef enum logic {TRAIN = 1'b0, ACTIVE = 1'b1} state_t;
  typedef enum logic [1:0] {NONE = 2'd0, R0 = 2'd1, R1 = 2'd2} owner_t;
endpackage

// File: rtl/phytx_rr_arb.sv
// phytx_rr_arb: bounded-burst round-robin arbiter between two requesters
module phytx_rr_arb import phytx_pkg::*; #(
  parameter int BURST = 4
) (
  input  logic clk_f,
  input  logic reset,
  input  logic en,
  input  logic flush,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel
);
  localparam int BW = $clog2(BURST + 1);
  owner_t owner;
  logic [BW-1:0] burst_cnt;
  logic rr_ptr;
  logic req_o, req_x, keep, any;
  // owner keeps the PHY while under its burst budget or uncontested; otherwise hand over
  always_comb begin
    req_o = owner == R1 ? req1 : req0;
    req_x = owner == R1 ? req0 : req1;
    keep  = owner != NONE && req_o && (burst_cnt < BW'(BURST) || !req_x);
    any   = req0 || req1;
    sel   = keep ? owner == R1 : owner != NONE ? owner == R0 : (rr_ptr ? req1 : !req0);
    gnt0  = en && any && !sel;
    gnt1  = en && any && sel;
  end
  // owner, burst length and round-robin pointer track the grant decisions
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      owner     <= NONE;
      burst_cnt <= '0;
      rr_ptr    <= 1'b0;
    end else if (flush) begin
      owner     <= NONE;
      burst_cnt <= '0;
    end else if (en) begin
      if (keep) begin
        burst_cnt <= (!req_x && burst_cnt == BW'(BURST)) ? '0 : burst_cnt + 1'b1;
      end else if (any) begin
        owner     <= sel ? R1 : R0;
        burst_cnt <= BW'(1);
        rr_ptr    <= !sel;
      end else begin
        owner     <= NONE;
        burst_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/phytx_sched.sv
// phytx_sched: word scheduler feeding the PHY with training, skip and arbitrated data words
module phytx_sched import phytx_pkg::*; #(
  parameter int          TRAIN_LEN   = 16,
  parameter int          BURST       = 4,
  parameter int          SKIP_PERIOD = 64,
  parameter logic [31:0] COM_WORD    = phytx_pkg::COM_WORD_DEF
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        retrain,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        link_up
);
  localparam int TW = TRAIN_LEN > 1 ? $clog2(TRAIN_LEN) : 1;
  localparam int SW = $clog2(SKIP_PERIOD);
  state_t state;
  logic [TW-1:0] train_cnt;
  logic [SW-1:0] skip_cnt;
  logic skip, en, flush, a_gnt0, a_gnt1, sel;
  phytx_rr_arb #(.BURST(BURST)) u_arb (
    .clk_f(clk_f), .reset(reset), .en(en), .flush(flush),
    .req0(req0), .req1(req1), .gnt0(a_gnt0), .gnt1(a_gnt1), .sel(sel)
  );
  // arbitration only runs on ordinary ACTIVE cycles; grants are masked during reset
  always_comb begin
    skip  = skip_cnt == SW'(SKIP_PERIOD - 1);
    en    = state == ACTIVE && !retrain && !skip;
    flush = state == ACTIVE && retrain;
    gnt0  = a_gnt0 && !reset;
    gnt1  = a_gnt1 && !reset;
  end
  // link FSM with training/skip counters and the registered PHY word
  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state     <= TRAIN;
      train_cnt <= '0;
      skip_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      link_up   <= 1'b0;
    end else if (state == TRAIN) begin
      data_out  <= COM_WORD;
      valid_out <= 1'b1;
      if (retrain) begin
        train_cnt <= '0;
      end else if (train_cnt >= TW'(TRAIN_LEN - 1)) begin
        state     <= ACTIVE;
        train_cnt <= '0;
        skip_cnt  <= '0;
        link_up   <= 1'b1;
      end else begin
        train_cnt <= train_cnt + 1'b1;
      end
    end else if (retrain) begin
      state     <= TRAIN;
      train_cnt <= TW'(1);
      data_out  <= COM_WORD;
      valid_out <= 1'b1;
      link_up   <= 1'b0;
    end else if (skip) begin
      skip_cnt  <= '0;
      data_out  <= COM_WORD;
      valid_out <= 1'b1;
    end else begin
      skip_cnt  <= skip_cnt + 1'b1;
      data_out  <= !(a_gnt0 || a_gnt1) ? '0 : sel ? data1 : data0;
      valid_out <= a_gnt0 || a_gnt1;
    end
  end
endmodule

// File: tb/tb_phytx_sched.sv
// tb_phytx_sched: directed stimulus with a cycle-level reference model of the scheduler
module tb_phytx_sched;
  localparam int TRAIN_LEN = 16;
  localparam int BURST = 4;
  localparam int SKIP_PERIOD = 64;
  localparam logic [31:0] COM = 32'hBCBCBCBC;
  logic clk_f = 1'b0;
  logic reset, retrain, req0, req1, gnt0, gnt1, valid_out, link_up;
  logic [31:0] data0, data1, data_out;
  int checks = 0;
  int passes = 0;
  logic g0n = 1'b0;
  logic g1n = 1'b0;
  int gr [83:148];
  logic [31:0] hv;
  bit m_act;
  int m_sent, m_pos, m_own, m_run, m_pref;
  logic [31:0] e_data;
  logic e_valid, e_link;

  phytx_sched dut (
    .clk_f(clk_f), .reset(reset), .retrain(retrain),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .data_out(data_out),
    .valid_out(valid_out), .link_up(link_up)
  );

  always #5 clk_f = ~clk_f;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
  endtask

  // advance one edge; a requester moves to its next word only when its grant was taken
  task automatic tick();
    logic rs;
    @(posedge clk_f);
    rs = reset;
    #1;
    if (g0n && !rs) data0 = data0 + 1;
    if (g1n && !rs) data1 = data1 + 1;
  endtask

  // reference model: compare last predicted outputs, predict grants now and outputs after the edge
  always @(negedge clk_f) begin
    int w;
    bit r [2];
    bit keep;
    if (reset) begin
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_data", data_out, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_link", link_up, 0);
      m_act = 0; m_sent = 0; m_pos = 0; m_own = -1; m_run = 0; m_pref = 0;
      e_data = 0; e_valid = 0; e_link = 0; g0n = 0; g1n = 0;
    end else begin
      chk("data_out", data_out, e_data);
      chk("valid_out", valid_out, e_valid);
      chk("link_up", link_up, e_link);
      w = -1;
      r[0] = req0; r[1] = req1;
      if (!m_act) begin
        e_data = COM; e_valid = 1;
        if (retrain) m_sent = 0;
        else begin
          m_sent++;
          if (m_sent == TRAIN_LEN) begin m_act = 1; m_pos = 0; e_link = 1; end
        end
      end else if (retrain) begin
        e_data = COM; e_valid = 1; m_act = 0; m_sent = 1; e_link = 0; m_own = -1; m_run = 0;
      end else if (m_pos == SKIP_PERIOD - 1) begin
        e_data = COM; e_valid = 1; m_pos = 0;
      end else begin
        m_pos++;
        keep = m_own >= 0 && r[m_own] && (m_run < BURST || !r[1-m_own]);
        if (keep) begin
          w = m_own;
          m_run = (!r[1-m_own] && m_run == BURST) ? 0 : m_run + 1;
        end else if (r[0] || r[1]) begin
          w = m_own >= 0 ? 1 - m_own : (r[m_pref] ? m_pref : 1 - m_pref);
          m_own = w; m_run = 1; m_pref = 1 - w;
        end else begin
          m_own = -1; m_run = 0;
        end
        e_data = w == 0 ? data0 : w == 1 ? data1 : 32'h0;
        e_valid = w >= 0;
      end
      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      chk("gnt_excl", gnt0 & gnt1, 0);
      g0n = gnt0; g1n = gnt1;
    end
  end

  initial begin
    reset = 1; retrain = 0; req0 = 0; req1 = 0;
    data0 = 32'h1; data1 = 32'hA0000001;
    repeat (2) @(posedge clk_f);
    #1 reset = 0;
    repeat (15) tick();
    chk("t1_train_link", link_up, 0);
    chk("t1_train_data", data_out, COM);
    tick();
    chk("t1_link_up", link_up, 1);
    chk("t1_last_com", data_out, COM);
    tick();
    chk("t1_idle_valid", valid_out, 0);
    req0 = 1;
    tick();
    chk("t2_first_word", data_out, 32'h1);
    repeat (62) tick();
    chk("t2_skip_word", data_out, COM);
    chk("t2_skip_valid", valid_out, 1);
    tick();
    chk("t2_resume", data_out, 32'd63);
    req0 = 0;
    tick();
    req0 = 1; req1 = 1;
    for (int e = 83; e <= 148; e++) begin
      @(negedge clk_f);
      gr[e] = gnt0 ? 0 : gnt1 ? 1 : 2;
      tick();
    end
    chk("t3_g83", gr[83], 1);
    chk("t3_g86", gr[86], 1);
    chk("t3_g87", gr[87], 0);
    chk("t3_g91", gr[91], 1);
    chk("t3_g143", gr[143], 0);
    chk("t3_skip144", gr[144], 2);
    chk("t3_g147", gr[147], 0);
    chk("t3_g148", gr[148], 1);
    tick();
    req1 = 0;
    @(negedge clk_f);
    chk("t4_handoff", gnt0, 1);
    tick();
    req1 = 1;
    repeat (3) tick();
    @(negedge clk_f);
    chk("t4_burst_restart", gnt1, 1);
    tick();
    req0 = 0;
    tick();
    retrain = 1;
    @(negedge clk_f);
    chk("t5_retrain_gnt1", gnt1, 0);
    tick();
    retrain = 0;
    chk("t5_retrain_com", data_out, COM);
    chk("t5_link_down", link_up, 0);
    hv = data1;
    repeat (14) tick();
    chk("t5_still_train", link_up, 0);
    tick();
    chk("t5_link_back", link_up, 1);
    tick();
    chk("t5_held_word", data_out, hv);
    req0 = 1;
    repeat (3) tick();
    #2 reset = 1;
    #1;
    chk("t6_async_data", data_out, 0);
    chk("t6_async_valid", valid_out, 0);
    chk("t6_async_gnt0", gnt0, 0);
    chk("t6_async_gnt1", gnt1, 0);
    tick();
    reset = 0;
    repeat (15) tick();
    chk("t6_retrain_link", link_up, 0);
    chk("t6_retrain_data", data_out, COM);
    tick();
    chk("t6_link_up", link_up, 1);
    repeat (6) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
